// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
package div_arb_pkg;

  // Transaction phases of the shared divider port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Widest operand this block is expected to be built with.
  localparam int MAX_DATA_W = 64;

  // Quotient returned for a zero divisor: all ones, sliced to DATA_W.
  localparam logic [MAX_DATA_W-1:0] DZ_QUOTIENT_ALL = '1;

  // The remainder carries one extra bit so a divide-by-zero can return
  // the sign-extended dividend.
  function automatic int rem_width(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/div_arbiter_rr_arbiter2.sv
// Two-input round-robin picker. The pointer names the requester that wins
// a tie and moves past whichever requester just completed service.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [1:0] req,
  input  logic       commit,
  input  logic       commit_id,
  output logic       grant_vld,
  output logic       grant_id
);

  logic ptr;

  // A lone request wins outright; a tie goes to the pointer.
  always_comb begin
    grant_vld = |req;
    grant_id  = 1'b0;
    if (req[0] && req[1]) begin
      grant_id = ptr;
    end else begin
      grant_id = req[1];
    end
  end

  // Point at the other requester once a service completes.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr <= 1'b0;
    end else if (commit) begin
      ptr <= ~commit_id;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider between two requesters: round-robin
// arbitration, operand capture, start/wait handshake with a watchdog,
// divide-by-zero short-circuit and a ready/valid response bus.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req0,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] y0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] y1,
  output logic              ack1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_quotient,
  output logic [DATA_W:0]   rsp_remainder,
  output logic              rsp_dz,
  output logic              rsp_err,
  output logic              div_start,
  output logic              div_abort,
  output logic [DATA_W-1:0] div_x,
  output logic [DATA_W-1:0] div_y,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_quotient,
  input  logic [DATA_W:0]   div_remainder
);

  localparam int REM_W = rem_width(DATA_W);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [DATA_W-1:0] DZ_QUOTIENT = DZ_QUOTIENT_ALL[DATA_W-1:0];

  state_t            state;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] y_q;
  logic [WD_W-1:0]   wd_cnt;
  logic [WD_W-1:0]   wd_next;
  logic              grant_vld;
  logic              grant_id;
  logic              rsp_fire;
  logic [DATA_W-1:0] win_x;
  logic [DATA_W-1:0] win_y;
  logic [REM_W-1:0]  dz_rem;

  assign win_x    = grant_id ? x1 : x0;
  assign win_y    = grant_id ? y1 : y0;
  assign dz_rem   = {win_x[DATA_W-1], win_x};
  assign wd_next  = wd_cnt + 1'b1;
  assign rsp_fire = (state == ST_RESP) && rsp_valid && rsp_ready;

  // Captured operands feed the divider directly and hold until the next capture.
  assign div_x = x_q;
  assign div_y = y_q;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst_b     (rst_b),
    .req       ({req1, req0}),
    .commit    (rsp_fire),
    .commit_id (rsp_id),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  // Transaction FSM with registered acks, divider strobes and response fields.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state         <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      wd_cnt        <= '0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      div_start     <= 1'b0;
      div_abort     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dz        <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      div_start <= 1'b0;
      div_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            x_q    <= win_x;
            y_q    <= win_y;
            rsp_id <= grant_id;
            ack0   <= ~grant_id;
            ack1   <= grant_id;
            if (win_y == '0) begin
              // Zero divisor: answer without touching the divider; rsp_valid
              // is raised one cycle later from RESP.
              rsp_dz        <= 1'b1;
              rsp_err       <= 1'b0;
              rsp_quotient  <= DZ_QUOTIENT;
              rsp_remainder <= dz_rem;
              state         <= ST_RESP;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          div_start <= 1'b1;
          wd_cnt    <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          wd_cnt <= wd_next;
          // A completion in the expiry cycle still counts as success.
          if (div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_dz        <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= ST_RESP;
          end else if (wd_next == WD_LIMIT) begin
            div_abort     <= 1'b1;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dz        <= 1'b0;
            rsp_err       <= 1'b1;
            rsp_valid     <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed scenarios plus randomized request mixes
// checked against an arithmetic reference and a round-robin order model.
module tb_div_arbiter;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  // Main instance (default watchdog)
  logic          req0, req1, ack0, ack1;
  logic [DW-1:0] x0, y0, x1, y1;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_dz, rsp_err;
  logic [DW-1:0] rsp_quotient;
  logic [DW:0]   rsp_remainder;
  logic          div_start, div_abort;
  logic [DW-1:0] div_x, div_y;
  logic          div_done = 1'b0;
  logic [DW-1:0] div_quotient = '0;
  logic [DW:0]   div_remainder = '0;

  // Short-watchdog instance
  logic          w_req, w_ack0, w_ack1, w_valid, w_ready, w_id, w_dz, w_err;
  logic          w_start, w_abort, w_done;
  logic [DW-1:0] w_x, w_y, w_q, w_dx, w_dy, w_dq;
  logic [DW:0]   w_r, w_dr;

  div_arbiter dut (
    .clk(clk), .rst_b(rst_b),
    .req0(req0), .x0(x0), .y0(y0), .ack0(ack0),
    .req1(req1), .x1(x1), .y1(y1), .ack1(ack1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dz(rsp_dz), .rsp_err(rsp_err),
    .div_start(div_start), .div_abort(div_abort), .div_x(div_x), .div_y(div_y),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  div_arbiter #(.TIMEOUT_CYCLES(16), .DATA_W(DW)) wdut (
    .clk(clk), .rst_b(rst_b),
    .req0(w_req), .x0(w_x), .y0(w_y), .ack0(w_ack0),
    .req1(1'b0), .x1('0), .y1('0), .ack1(w_ack1),
    .rsp_valid(w_valid), .rsp_ready(w_ready), .rsp_id(w_id),
    .rsp_quotient(w_q), .rsp_remainder(w_r),
    .rsp_dz(w_dz), .rsp_err(w_err),
    .div_start(w_start), .div_abort(w_abort), .div_x(w_dx), .div_y(w_dy),
    .div_done(w_done), .div_quotient(w_dq), .div_remainder(w_dr)
  );

  // Behavioural divider for the main instance: done pulses lat_cfg cycles after start.
  int            lat_cfg = 4;
  int            start_cnt = 0;
  int            dcnt = 0;
  bit            dbusy = 1'b0;
  logic [DW-1:0] dmx, dmy;
  always @(negedge clk) begin
    div_done = 1'b0;
    if (!rst_b) begin
      dbusy = 1'b0;
    end else if (div_start) begin
      dbusy = 1'b1;
      dcnt  = lat_cfg;
      dmx   = div_x;
      dmy   = div_y;
      start_cnt++;
    end else if (dbusy) begin
      if (dcnt <= 1) begin
        div_done      = 1'b1;
        div_quotient  = dmx / dmy;
        div_remainder = {1'b0, dmx % dmy};
        dbusy         = 1'b0;
      end else begin
        dcnt--;
      end
    end
  end

  int checks = 0;
  int failures = 0;
  bit last_id;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference result from plain arithmetic.
  function automatic void ref_div(input logic [DW-1:0] x, input logic [DW-1:0] y, input bit hang,
                                  output logic [DW-1:0] q, output logic [DW:0] r,
                                  output logic dz, output logic err);
    dz  = (y == '0);
    err = 1'b0;
    if (dz) begin
      q = '1;
      r = {x[DW-1], x};
    end else if (hang) begin
      q = '0;
      r = '0;
      err = 1'b1;
    end else begin
      q = x / y;
      r = {1'b0, x % y};
    end
  endfunction

  function automatic logic [DW-1:0] rand_y();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return DW'($urandom_range(1, 300));
      default: return DW'($urandom) | 32'd1;
    endcase
  endfunction

  // One full service on the main instance: ack, issue, response, handshake.
  task automatic serve(input bit exp_id, input logic [DW-1:0] x, input logic [DW-1:0] y,
                       input int stall);
    logic [DW-1:0] eq;
    logic [DW:0]   er;
    logic          edz, eerr;
    int            n, s0;
    ref_div(x, y, 1'b0, eq, er, edz, eerr);
    s0 = start_cnt;
    n = 0;
    while (!(ack0 || ack1) && n < 300) begin
      step();
      n++;
    end
    check("ack_seen", ack0 | ack1, 1);
    check("ack_id", ack1, exp_id);
    check("ack_onehot", ack0 & ack1, 0);
    check("rsp_idle_at_ack", rsp_valid, 0);
    if (ack1) req1 = 1'b0;
    else req0 = 1'b0;
    step();
    check("ack_pulse", ack0 | ack1, 0);
    if (edz) begin
      check("dz_no_start", div_start, 0);
      check("dz_latency", rsp_valid, 1);
    end else begin
      check("start_latency", div_start, 1);
      check("div_x", div_x, x);
      check("div_y", div_y, y);
    end
    n = 0;
    while (!rsp_valid && n < 300) begin
      step();
      n++;
    end
    check("rsp_valid", rsp_valid, 1);
    check("start_count", start_cnt - s0, edz ? 0 : 1);
    for (int i = 0; i <= stall; i++) begin
      check("rsp_id", rsp_id, exp_id);
      check("rsp_quotient", rsp_quotient, eq);
      check("rsp_remainder", rsp_remainder, er);
      check("rsp_dz", rsp_dz, edz);
      check("rsp_err", rsp_err, eerr);
      if (i > 0) begin
        check("stall_valid", rsp_valid, 1);
        check("stall_no_ack", ack0 | ack1, 0);
      end
      if (i == stall) rsp_ready = 1'b1;
      step();
    end
    rsp_ready = 1'b0;
    check("rsp_one_cycle", rsp_valid, 0);
    last_id = exp_id;
  endtask

  initial begin
    int            n;
    logic [DW-1:0] eq;
    logic [DW:0]   er;
    logic          edz, eerr;
    rst_b = 1'b0;
    req0 = 1'b0; req1 = 1'b0; x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    rsp_ready = 1'b0;
    w_req = 1'b0; w_x = '0; w_y = '0; w_ready = 1'b0; w_done = 1'b0; w_dq = '0; w_dr = '0;
    step(2);
    // Reset state
    check("rst_ctrl", {ack0, ack1, rsp_valid, rsp_id, rsp_dz, rsp_err, div_start, div_abort}, 0);
    check("rst_q", rsp_quotient, 0);
    check("rst_r", rsp_remainder, 0);
    check("rst_dx", div_x, 0);
    check("rst_dy", div_y, 0);
    check("rst_w_ctrl", {w_ack0, w_valid, w_start, w_abort, w_err}, 0);
    rst_b = 1'b1;
    last_id = 1'b1;
    step();

    // Simultaneous pairs after reset: 0 first, then 1, and again 0 then 1
    for (int k = 0; k < 2; k++) begin
      req0 = 1'b1; x0 = 100; y0 = 7;
      req1 = 1'b1; x1 = 100; y1 = 7;
      serve(1'b0, 100, 7, 0);
      serve(1'b1, 100, 7, 0);
    end

    // Single request, slow divider
    lat_cfg = 40;
    req0 = 1'b1; x0 = 4802; y0 = 172;
    serve(1'b0, 4802, 172, 0);

    // Divide by zero on port 1
    req1 = 1'b1; x1 = 32'h8000_0005; y1 = '0;
    serve(1'b1, 32'h8000_0005, 32'h0, 0);

    // Backpressure with a pending second requester
    lat_cfg = 5;
    req0 = 1'b1; x0 = 32'd123456; y0 = 32'd789;
    req1 = 1'b1; x1 = 32'd999; y1 = 32'd10;
    serve(~last_id, 32'd123456, 32'd789, 10);
    serve(~last_id, 32'd999, 32'd10, 0);

    // Randomized request mixes
    for (int it = 0; it < 30; it++) begin
      bit            m0, m1, first;
      logic [DW-1:0] ax, ay, bx, by;
      int            st;
      m0 = 1'($urandom_range(0, 1));
      m1 = 1'($urandom_range(0, 1));
      if (!m0 && !m1) m0 = 1'b1;
      ax = DW'($urandom); ay = rand_y();
      bx = DW'($urandom); by = rand_y();
      lat_cfg = $urandom_range(1, 30);
      st = $urandom_range(0, 3);
      req0 = m0; x0 = ax; y0 = ay;
      req1 = m1; x1 = bx; y1 = by;
      first = (m0 && m1) ? ~last_id : m1;
      serve(first, first ? bx : ax, first ? by : ay, st);
      if (m0 && m1) serve(~first, first ? ax : bx, first ? ay : by, st);
    end

    // Watchdog: hung divider on the short-timeout instance
    w_req = 1'b1; w_x = 123; w_y = 5;
    n = 0;
    while (!w_ack0 && n < 50) begin step(); n++; end
    check("wd_ack", w_ack0, 1);
    w_req = 1'b0;
    n = 0;
    while (!w_start && n < 50) begin step(); n++; end
    check("wd_start", w_start, 1);
    n = 0;
    while (!w_abort && n < 100) begin step(); n++; end
    check("wd_abort_cycles", n, 16);
    ref_div(123, 5, 1'b1, eq, er, edz, eerr);
    check("wd_valid", w_valid, 1);
    check("wd_err", w_err, eerr);
    check("wd_dz", w_dz, edz);
    check("wd_q", w_q, eq);
    check("wd_r", w_r, er);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    check("wd_abort_pulse", w_abort, 0);
    check("wd_rsp_done", w_valid, 0);
    // Next request completes normally
    w_req = 1'b1; w_x = 1000; w_y = 9;
    n = 0;
    while (!w_ack0 && n < 50) begin step(); n++; end
    check("wd2_ack", w_ack0, 1);
    w_req = 1'b0;
    n = 0;
    while (!w_start && n < 50) begin step(); n++; end
    check("wd2_start", w_start, 1);
    ref_div(1000, 9, 1'b0, eq, er, edz, eerr);
    step(3);
    w_done = 1'b1; w_dq = eq; w_dr = er;
    step();
    w_done = 1'b0;
    check("wd2_valid", w_valid, 1);
    check("wd2_err", w_err, 0);
    check("wd2_abort", w_abort, 0);
    check("wd2_q", w_q, 111);
    check("wd2_r", w_r, 1);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;

    // Reset in the middle of WAIT
    lat_cfg = 100;
    req0 = 1'b1; x0 = 32'd5000; y0 = 32'd3;
    n = 0;
    while (!ack0 && n < 50) begin step(); n++; end
    check("mid_ack", ack0, 1);
    req0 = 1'b0;
    step(5);
    rst_b = 1'b0;
    #1;
    check("async_ctrl", {ack0, ack1, rsp_valid, rsp_id, rsp_dz, rsp_err, div_start, div_abort}, 0);
    check("async_dx", div_x, 0);
    check("async_dy", div_y, 0);
    check("async_q", rsp_quotient, 0);
    check("async_r", rsp_remainder, 0);
    step();
    rst_b = 1'b1;
    last_id = 1'b1;
    lat_cfg = 3;
    req0 = 1'b1; x0 = 9; y0 = 2;
    step();
    check("idle_after_reset", ack0, 1);
    serve(1'b0, 9, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one sequential 32-bit divider unit between two requesters (ports 0 and 1).
- Arbitrates requests round-robin and captures the winner's operands.
- Issues a one-cycle start to the divider, waits for its completion flag, and returns quotient/remainder on a shared response bus with ready/valid backpressure.
- Short-circuits divide-by-zero and guards against a hung divider with a watchdog.
- Sits between the instruction-level issue logic and the divider datapath.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT before abort; counter width is clog2(TIMEOUT_CYCLES+1).
- DATA_W, 32: operand width. Quotient is DATA_W bits; remainder is DATA_W+1 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst_b  in  1  asynchronous active-low reset
- req0  in  1  requester 0 request; held high until ack0
- x0  in  DATA_W  requester 0 dividend
- y0  in  DATA_W  requester 0 divisor
- ack0  out  1  one-cycle pulse: operands of requester 0 captured
- req1, x1, y1, ack1: same as above, for requester 1
- rsp_valid  out  1  response valid; held until rsp_ready
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index of the response
- rsp_quotient  out  DATA_W  quotient
- rsp_remainder  out  DATA_W+1  remainder
- rsp_dz  out  1  divide-by-zero flag
- rsp_err  out  1  watchdog timeout flag
- div_start  out  1  one-cycle start pulse to the divider
- div_abort  out  1  one-cycle abort pulse to the divider on timeout
- div_x  out  DATA_W  dividend to the divider; stable from ISSUE until leaving WAIT
- div_y  out  DATA_W  divisor to the divider; stable from ISSUE until leaving WAIT
- div_done  in  1  divider completion flag (a pulse or a level; only first-high is used)
- div_quotient  in  DATA_W  divider quotient, valid while div_done
- div_remainder  in  DATA_W+1  divider remainder, valid while div_done

Behaviour:
- Reset (rst_b low, asynchronous):
  - State IDLE; priority pointer = 0.
  - All outputs 0; operand and result registers 0; watchdog counter 0.
  - Reset mid-operation abandons the transaction silently. No div_abort is issued; the divider shares rst_b.
- States: IDLE, ISSUE, WAIT, RESP (one-hot or binary; encoding lives in the package).
- IDLE:
  - Samples req0/req1 at each rising edge.
  - Single request: that requester wins. Both requests: the requester named by the pointer wins.
  - The winner's x/y are registered at that edge. The matching ack is registered high for exactly the next cycle.
  - If the captured y == 0: go to RESP with rsp_dz=1, rsp_quotient = all ones, rsp_remainder = {x[DATA_W-1], x}. The divider is not touched.
  - Otherwise go to ISSUE.
- ISSUE: div_start=1 for this one cycle; watchdog cleared; next state WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - div_done high: capture div_quotient and div_remainder, go to RESP with rsp_dz=0, rsp_err=0.
  - Watchdog == TIMEOUT_CYCLES without div_done: div_abort pulses 1 cycle; go to RESP with rsp_err=1 and zero data.
  - div_done high in the same cycle the watchdog expires: done wins, err=0.
- RESP:
  - rsp_valid=1; rsp_id and data are stable while rsp_valid is high and rsp_ready is low.
  - On rsp_valid && rsp_ready at an edge: go to IDLE, pointer = ~rsp_id.
  - rsp_ready may be held high permanently; the response then lasts exactly 1 cycle.
- Requester protocol:
  - A requester's req must not fall before its ack.
  - req still high after ack is a new request, which is eligible only after returning to IDLE.
  - A losing requester stays pending; no starvation, because the pointer alternates.
- Latency: req sampled → ack next cycle → div_start next cycle → response 1 cycle after div_done.
  - Divide-by-zero response: 1 cycle after capture.
- Only one transaction is in flight at a time; requests during ISSUE/WAIT/RESP are ignored until IDLE.

Decomposition:
- Package div_arb_pkg holds:
  - the state enum/localparams;
  - DATA_W-derived widths;
  - the divide-by-zero quotient constant (all ones).
- One natural sub-module, rr_arbiter2: 2-input round-robin picker with pointer update on a grant-commit strobe (about 40 lines).
- FSM, operand/result registers and watchdog stay in div_arbiter.

Test Plan:
1. req0 with x0=4802, y0=172; divider model returns after 40 cycles.
   - Required: ack0 pulses once; div_start one pulse with div_x=4802, div_y=172; rsp_id=0, quotient=27, remainder=158, dz=0, err=0.
2. req0 and req1 asserted in the same cycle after reset, both x=100 and y=7.
   - Required: requester 0 served first (rsp_id=0), then requester 1 (rsp_id=1); a third simultaneous pair is served 0 first again, since the pointer alternates after each service.
3. req1 with x1=0x80000005, y1=0.
   - Required: no div_start; response 2 cycles after the req sample; rsp_dz=1, rsp_quotient=0xFFFFFFFF, rsp_remainder=0x1_80000005.
4. Divider model never asserts done, TIMEOUT_CYCLES=16.
   - Required: div_abort pulses exactly 16 cycles after the WAIT entry; rsp_err=1, data 0; arbiter returns to IDLE and serves the next request normally.
5. Backpressure: rsp_ready held low for 10 cycles during a response.
   - Required: rsp_valid and all rsp_* fields stay stable for those 10 cycles; a pending req1 gets no ack until the RESP handshake completes.
6. rst_b driven low for 1 cycle during WAIT.
   - Required: all outputs 0 immediately (asynchronously); after release the FSM is in IDLE, and a fresh req0 with x=9, y=2 gives quotient=4, remainder=1.
